// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the 4-bit state encodings, the opcode map, the datapath mux/ALU
// select codes, the one-hot beat constants and the control-vector struct
// that the decode sub-module produces for the top.
package mc_ctrl_pkg;

    // State encodings: INIT and FETCH first, the rest in datapath order.
    localparam logic [3:0] ST_INIT     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_MEM_ADDR = 4'd3;
    localparam logic [3:0] ST_MEM_RD   = 4'd4;
    localparam logic [3:0] ST_WB_MEM   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_EXEC_R   = 4'd7;
    localparam logic [3:0] ST_WB_R     = 4'd8;
    localparam logic [3:0] ST_EXEC_I   = 4'd9;
    localparam logic [3:0] ST_WB_I     = 4'd10;
    localparam logic [3:0] ST_BRANCH   = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;
    localparam logic [3:0] ST_JAL      = 4'd13;
    localparam logic [3:0] ST_HALT     = 4'd14;
    localparam logic [3:0] ST_TRAP     = 4'd15;

    // Opcode map (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // ALU operation select.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B-operand select.
    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    // Register write-data select.
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // Register destination select.
    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    // PC source select.
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // One-hot phase indicators.
    localparam logic [4:0] BEAT_NONE = 5'b00000;
    localparam logic [4:0] BEAT_0    = 5'b00001;
    localparam logic [4:0] BEAT_1    = 5'b00010;
    localparam logic [4:0] BEAT_2    = 5'b00100;
    localparam logic [4:0] BEAT_3    = 5'b01000;
    localparam logic [4:0] BEAT_4    = 5'b10000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       ir_write;
        logic       reg_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [4:0] beat;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'({$bits(ctrl_t){1'b0}});

    // DECODE dispatch target for an opcode; unknown opcodes trap.
    function automatic logic [3:0] dispatch(input logic [5:0] op);
        logic [3:0] tgt;
        case (op)
            OP_LW, OP_SW:   tgt = ST_MEM_ADDR;
            OP_RTYPE:       tgt = ST_EXEC_R;
            OP_ADDI:        tgt = ST_EXEC_I;
            OP_BEQ, OP_BNE: tgt = ST_BRANCH;
            OP_J:           tgt = ST_JUMP;
            OP_JAL:         tgt = ST_JAL;
            OP_HALT:        tgt = ST_HALT;
            default:        tgt = ST_TRAP;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure combinational control decode for the multicycle controller.
// Ports:
//   i_state     - current FSM state encoding
//   i_opcode    - IR opcode (only BRANCH looks at it, to split BEQ/BNE)
//   i_mem_ready - effective memory-ready, gates PC/IR writes in FETCH
//   o_ctrl      - full control vector; any control not set for a state is 0
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    // Per-state control vector, starting from an all-zero vector.
    always_comb begin
        o_ctrl = CTRL_NONE;
        case (i_state)
            ST_INIT: begin
                o_ctrl = CTRL_NONE;
            end
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ASB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCS_ALU;
                // PC+4 and IR latch only on the cycle the fetch completes.
                o_ctrl.pc_write  = i_mem_ready;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.beat      = BEAT_0;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_b = ASB_IMM_SH;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.beat      = BEAT_1;
            end
            ST_MEM_ADDR, ST_EXEC_I: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ASB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.beat      = BEAT_2;
            end
            ST_MEM_RD: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.mem_read = 1'b1;
                o_ctrl.beat     = BEAT_3;
            end
            ST_WB_MEM: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = M2R_MDR;
                o_ctrl.reg_dst    = RDST_RT;
                o_ctrl.beat       = BEAT_4;
            end
            ST_MEM_WR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.beat      = BEAT_3;
            end
            ST_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ASB_B;
                o_ctrl.alu_op    = ALU_FUNCT;
                o_ctrl.beat      = BEAT_2;
            end
            ST_WB_R: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RD;
                o_ctrl.mem_to_reg = M2R_ALUOUT;
                o_ctrl.beat       = BEAT_3;
            end
            ST_WB_I: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RT;
                o_ctrl.mem_to_reg = M2R_ALUOUT;
                o_ctrl.beat       = BEAT_3;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a        = 1'b1;
                o_ctrl.alu_src_b        = ASB_B;
                o_ctrl.alu_op           = ALU_SUB;
                o_ctrl.pc_source        = PCS_ALUOUT;
                o_ctrl.pc_write_cond    = (i_opcode == OP_BEQ);
                o_ctrl.pc_write_cond_ne = (i_opcode == OP_BNE);
                o_ctrl.beat             = BEAT_2;
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCS_JUMP;
                o_ctrl.beat      = BEAT_2;
            end
            ST_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCS_JUMP;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RA;
                o_ctrl.mem_to_reg = M2R_PC;
                o_ctrl.beat       = BEAT_2;
            end
            ST_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            ST_TRAP: begin
                o_ctrl.illegal = 1'b1;
            end
            default: begin
                o_ctrl = CTRL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: state register, next-state logic and the
// retired-instruction counter. Control outputs are a combinational decode
// of the state (see mc_ctrl_decode), so they are all 0 while in INIT/reset.
// Ports:
//   i_clk, i_rst           - clock, asynchronous active-high reset
//   i_opcode               - IR opcode, stable outside FETCH
//   i_mem_ready            - memory completes current access this cycle
//   o_pc_write .. o_pc_source - datapath controls
//   o_beat                 - one-hot phase indicator
//   o_halted / o_illegal   - HALT executed / undefined opcode trapped
//   o_retired_count        - retired instructions, wraps
//   o_state_out            - current state encoding
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int CNT_W       = 32,
    parameter int MEM_WAIT_EN = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_mem_ready,
    output logic                o_pc_write,
    output logic                o_pc_write_cond,
    output logic                o_pc_write_cond_ne,
    output logic                o_ir_write,
    output logic                o_reg_write,
    output logic                o_iord,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_alu_src_a,
    output logic [1:0]          o_mem_to_reg,
    output logic [1:0]          o_reg_dst,
    output logic [1:0]          o_alu_src_b,
    output logic [1:0]          o_alu_op,
    output logic [1:0]          o_pc_source,
    output logic [4:0]          o_beat,
    output logic                o_halted,
    output logic                o_illegal,
    output logic [CNT_W-1:0]    o_retired_count,
    output logic [3:0]          o_state_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_count;
    logic [5:0]       w_op;
    logic             w_ready;
    logic             w_retire;
    ctrl_t            w_ctrl;

    assign w_op    = 6'(i_opcode);
    // With wait states disabled the memory is treated as always ready.
    assign w_ready = (MEM_WAIT_EN != 0) ? i_mem_ready : 1'b1;

    // Next-state selection.
    always_comb begin
        w_next = ST_INIT;
        case (r_state)
            ST_INIT:     w_next = ST_FETCH;
            ST_FETCH:    w_next = w_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:   w_next = dispatch(w_op);
            ST_MEM_ADDR: w_next = (w_op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   w_next = w_ready ? ST_WB_MEM : ST_MEM_RD;
            ST_MEM_WR:   w_next = w_ready ? ST_FETCH : ST_MEM_WR;
            ST_EXEC_R:   w_next = ST_WB_R;
            ST_EXEC_I:   w_next = ST_WB_I;
            ST_WB_MEM, ST_WB_R, ST_WB_I,
            ST_BRANCH, ST_JUMP, ST_JAL:
                         w_next = ST_FETCH;
            ST_HALT:     w_next = ST_HALT;
            ST_TRAP:     w_next = ST_TRAP;
            default:     w_next = ST_INIT;
        endcase
    end

    // An instruction retires when it returns to FETCH from anywhere but
    // INIT (the reset entry), or when HALT is dispatched.
    always_comb begin
        if (w_next == ST_FETCH) begin
            w_retire = (r_state != ST_INIT) && (r_state != ST_FETCH);
        end else if ((r_state == ST_DECODE) && (w_next == ST_HALT)) begin
            w_retire = 1'b1;
        end else begin
            w_retire = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (w_retire) begin
            r_count <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (w_op),
        .i_mem_ready (w_ready),
        .o_ctrl      (w_ctrl)
    );

    assign o_pc_write         = w_ctrl.pc_write;
    assign o_pc_write_cond    = w_ctrl.pc_write_cond;
    assign o_pc_write_cond_ne = w_ctrl.pc_write_cond_ne;
    assign o_ir_write         = w_ctrl.ir_write;
    assign o_reg_write        = w_ctrl.reg_write;
    assign o_iord             = w_ctrl.iord;
    assign o_mem_read         = w_ctrl.mem_read;
    assign o_mem_write        = w_ctrl.mem_write;
    assign o_alu_src_a        = w_ctrl.alu_src_a;
    assign o_mem_to_reg       = w_ctrl.mem_to_reg;
    assign o_reg_dst          = w_ctrl.reg_dst;
    assign o_alu_src_b        = w_ctrl.alu_src_b;
    assign o_alu_op           = w_ctrl.alu_op;
    assign o_pc_source        = w_ctrl.pc_source;
    assign o_beat             = w_ctrl.beat;
    assign o_halted           = w_ctrl.halted;
    assign o_illegal          = w_ctrl.illegal;
    assign o_retired_count    = r_count;
    assign o_state_out        = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: an instruction-level model
// (each opcode expands to its list of phases) predicts state, controls and
// retired count every cycle; directed sequences pin the model with literals.
module tb_mc_control_fsm;

    // Spec state numbering.
    localparam logic [3:0] B_INIT = 4'd0,  B_F = 4'd1,   B_D = 4'd2,   B_MA = 4'd3,
                           B_MRD = 4'd4,  B_WBM = 4'd5, B_MWR = 4'd6, B_EXR = 4'd7,
                           B_WBR = 4'd8,  B_EXI = 4'd9, B_WBI = 4'd10, B_BR = 4'd11,
                           B_JMP = 4'd12, B_JAL = 4'd13, B_HALT = 4'd14, B_TRAP = 4'd15;
    localparam logic [5:0] C_R = 6'b000000, C_J = 6'b000010, C_JAL = 6'b000011,
                           C_BEQ = 6'b000100, C_BNE = 6'b000101, C_ADDI = 6'b001000,
                           C_LW = 6'b100011, C_SW = 6'b101011, C_HALT = 6'b111111,
                           C_ILL = 6'b010101;

    typedef logic [3:0] seq_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'b000000;
    logic        mem_ready = 1'b1;
    logic        pcw, pcwc, pcwcne, irw, rw, iord, mr, mw, asa, halted, illegal;
    logic [1:0]  m2r, rdst, asb, aop, psrc;
    logic [4:0]  beat;
    logic [31:0] count;
    logic [3:0]  state;
    logic [25:0] dut_vec;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.OPCODE_W(6), .CNT_W(32), .MEM_WAIT_EN(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_mem_ready(mem_ready),
        .o_pc_write(pcw), .o_pc_write_cond(pcwc), .o_pc_write_cond_ne(pcwcne),
        .o_ir_write(irw), .o_reg_write(rw), .o_iord(iord), .o_mem_read(mr),
        .o_mem_write(mw), .o_alu_src_a(asa), .o_mem_to_reg(m2r), .o_reg_dst(rdst),
        .o_alu_src_b(asb), .o_alu_op(aop), .o_pc_source(psrc), .o_beat(beat),
        .o_halted(halted), .o_illegal(illegal), .o_retired_count(count),
        .o_state_out(state)
    );

    assign dut_vec = {pcw, pcwc, pcwcne, irw, rw, iord, mr, mw, asa,
                      m2r, rdst, asb, aop, psrc, beat, halted, illegal};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Phase list of one instruction, starting at its FETCH.
    function automatic seq_t seq_for(input logic [5:0] op);
        case (op)
            C_LW:         return '{B_F, B_D, B_MA, B_MRD, B_WBM};
            C_SW:         return '{B_F, B_D, B_MA, B_MWR};
            C_R:          return '{B_F, B_D, B_EXR, B_WBR};
            C_ADDI:       return '{B_F, B_D, B_EXI, B_WBI};
            C_BEQ, C_BNE: return '{B_F, B_D, B_BR};
            C_J:          return '{B_F, B_D, B_JMP};
            C_JAL:        return '{B_F, B_D, B_JAL};
            C_HALT:       return '{B_F, B_D, B_HALT};
            default:      return '{B_F, B_D, B_TRAP};
        endcase
    endfunction

    // Expected controls for a phase, straight from the per-state control table.
    function automatic logic [25:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                             input logic rdy);
        logic e_pcw = 1'b0, e_pcwc = 1'b0, e_pcwcne = 1'b0, e_irw = 1'b0, e_rw = 1'b0;
        logic e_iord = 1'b0, e_mr = 1'b0, e_mw = 1'b0, e_asa = 1'b0, e_h = 1'b0, e_i = 1'b0;
        logic [1:0] e_m2r = 2'd0, e_rdst = 2'd0, e_asb = 2'd0, e_aop = 2'd0, e_psrc = 2'd0;
        logic [4:0] e_beat = 5'd0;
        case (st)
            B_F:    begin e_mr = 1'b1; e_asb = 2'd1; e_pcw = rdy; e_irw = rdy; e_beat = 5'd1; end
            B_D:    begin e_asb = 2'd3; e_beat = 5'd2; end
            B_MA,
            B_EXI:  begin e_asa = 1'b1; e_asb = 2'd2; e_beat = 5'd4; end
            B_MRD:  begin e_iord = 1'b1; e_mr = 1'b1; e_beat = 5'd8; end
            B_WBM:  begin e_rw = 1'b1; e_m2r = 2'd1; e_beat = 5'd16; end
            B_MWR:  begin e_iord = 1'b1; e_mw = 1'b1; e_beat = 5'd8; end
            B_EXR:  begin e_asa = 1'b1; e_aop = 2'd2; e_beat = 5'd4; end
            B_WBR:  begin e_rw = 1'b1; e_rdst = 2'd1; e_beat = 5'd8; end
            B_WBI:  begin e_rw = 1'b1; e_beat = 5'd8; end
            B_BR:   begin e_asa = 1'b1; e_aop = 2'd1; e_psrc = 2'd1; e_beat = 5'd4;
                          e_pcwc = (op == C_BEQ); e_pcwcne = (op == C_BNE); end
            B_JMP:  begin e_pcw = 1'b1; e_psrc = 2'd2; e_beat = 5'd4; end
            B_JAL:  begin e_pcw = 1'b1; e_psrc = 2'd2; e_rw = 1'b1; e_rdst = 2'd2;
                          e_m2r = 2'd2; e_beat = 5'd4; end
            B_HALT: e_h = 1'b1;
            B_TRAP: e_i = 1'b1;
            default: e_beat = 5'd0;
        endcase
        return {e_pcw, e_pcwc, e_pcwcne, e_irw, e_rw, e_iord, e_mr, e_mw, e_asa,
                e_m2r, e_rdst, e_asb, e_aop, e_psrc, e_beat, e_h, e_i};
    endfunction

    // Reference model: current instruction's phase list and position in it.
    seq_t        m_seq;
    int          m_idx = 0;
    logic [31:0] m_count = 32'd0;

    always @(posedge clk or posedge rst) begin : model
        logic [3:0] cur;
        if (rst) begin
            m_seq = '{B_INIT}; m_idx = 0; m_count = 32'd0;
        end else begin
            cur = m_seq[m_idx];
            if (cur == B_INIT) begin
                m_seq = '{B_F}; m_idx = 0;
            end else if ((cur == B_F || cur == B_MRD || cur == B_MWR) && !mem_ready) begin
                m_idx = m_idx;
            end else if (cur == B_HALT || cur == B_TRAP) begin
                m_idx = m_idx;
            end else if (cur == B_F) begin
                m_seq = seq_for(opcode); m_idx = 1;
            end else if (m_idx == m_seq.size() - 1) begin
                m_seq = '{B_F}; m_idx = 0; m_count = m_count + 32'd1;
            end else begin
                m_idx = m_idx + 1;
                if (m_seq[m_idx] == B_HALT) m_count = m_count + 32'd1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin : cmp
        logic [3:0] st;
        st = m_seq[m_idx];
        check("ctrl", {6'd0, dut_vec}, {6'd0, exp_ctrl(st, opcode, mem_ready)});
        check("state", {28'd0, state}, {28'd0, st});
        check("count", count, m_count);
    end

    // Snapshot of the last directed cycle's outputs.
    logic [25:0] s_vec;
    logic [3:0]  s_state;

    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] exp_st,
                       input string nm);
        opcode = op; mem_ready = rdy;
        @(negedge clk);
        s_vec = dut_vec; s_state = state;
        check(nm, {28'd0, s_state}, {28'd0, exp_st});
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Field extraction from the 26-bit snapshot (bit positions of dut_vec).
    function automatic logic [7:0] f_br(input logic [25:0] v);   // pcwc, pcwcne, aop, psrc
        return {2'b00, v[24], v[23], v[10:9], v[8:7]};
    endfunction

    logic [5:0] pick_ops [8] = '{C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_BNE, C_J, C_JAL};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_ctrl", {6'd0, dut_vec}, 32'd0);
        check("rst_count", count, 32'd0);
        rst = 1'b0;

        // R-type from reset release.
        cyc(C_R, 1'b1, B_INIT, "r_init");
        cyc(C_R, 1'b1, B_F,    "r_fetch");
        cyc(C_R, 1'b1, B_D,    "r_decode");
        cyc(C_R, 1'b1, B_EXR,  "r_exec");
        check("r_exec_rw", {31'd0, s_vec[21]}, 32'd0);
        cyc(C_R, 1'b1, B_WBR,  "r_wb");
        check("r_wb_rw_rdst", {29'd0, s_vec[21], s_vec[14:13]}, {29'd0, 1'b1, 2'b01});

        // LW with two stall cycles in MEM_RD: 7 cycles total.
        cyc(C_LW, 1'b1, B_F, "lw_fetch");
        check("r_retired", count, 32'd1);
        cyc(C_LW, 1'b1, B_D,   "lw_decode");
        cyc(C_LW, 1'b1, B_MA,  "lw_addr");
        cyc(C_LW, 1'b0, B_MRD, "lw_rd0");
        check("lw_rd_iord_mr", {30'd0, s_vec[20], s_vec[19]}, 32'd3);
        cyc(C_LW, 1'b0, B_MRD, "lw_rd1");
        cyc(C_LW, 1'b1, B_MRD, "lw_rd2");
        check("lw_rd2_iord_mr", {30'd0, s_vec[20], s_vec[19]}, 32'd3);
        cyc(C_LW, 1'b1, B_WBM, "lw_wb");
        check("lw_wb_m2r", {30'd0, s_vec[16:15]}, 32'd1);

        // BNE then BEQ.
        cyc(C_BNE, 1'b1, B_F, "bne_fetch");
        check("lw_retired", count, 32'd2);
        cyc(C_BNE, 1'b1, B_D,  "bne_decode");
        cyc(C_BNE, 1'b1, B_BR, "bne_branch");
        check("bne_ctrl", {24'd0, f_br(s_vec)}, {24'd0, 8'b0001_0101});
        cyc(C_BEQ, 1'b1, B_F,  "beq_fetch");
        cyc(C_BEQ, 1'b1, B_D,  "beq_decode");
        cyc(C_BEQ, 1'b1, B_BR, "beq_branch");
        check("beq_ctrl", {24'd0, f_br(s_vec)}, {24'd0, 8'b0010_0101});

        // JAL.
        cyc(C_JAL, 1'b1, B_F,   "jal_fetch");
        check("br_retired", count, 32'd4);
        cyc(C_JAL, 1'b1, B_D,   "jal_decode");
        cyc(C_JAL, 1'b1, B_JAL, "jal_exec");
        check("jal_ctrl", {23'd0, s_vec[25], s_vec[21], s_vec[16:13], s_vec[8:7]},
              {23'd0, 1'b1, 1'b1, 2'b10, 2'b10, 2'b10});

        // HALT is sticky and counts once.
        cyc(C_HALT, 1'b1, B_F, "halt_fetch");
        check("jal_retired", count, 32'd5);
        cyc(C_HALT, 1'b1, B_D, "halt_decode");
        for (int i = 0; i < 20; i++) begin
            cyc(C_HALT, 1'($urandom_range(0, 1)), B_HALT, "halt_hold");
            check("halt_vec", {6'd0, s_vec}, 32'd2);
        end
        check("halt_retired", count, 32'd6);

        // Illegal opcode traps without counting.
        pulse_reset();
        cyc(C_ILL, 1'b1, B_INIT, "ill_init");
        cyc(C_ILL, 1'b1, B_F,    "ill_fetch");
        cyc(C_ILL, 1'b1, B_D,    "ill_decode");
        for (int i = 0; i < 5; i++) begin
            cyc(C_ILL, 1'b1, B_TRAP, "ill_hold");
            check("ill_vec", {6'd0, s_vec}, 32'd1);
        end
        check("ill_count", count, 32'd0);

        // Reset while SW is stalled in MEM_WR.
        pulse_reset();
        cyc(C_R, 1'b1, B_INIT, "sw_pre_init");
        cyc(C_R, 1'b1, B_F, "sw_pre_f");
        cyc(C_R, 1'b1, B_D, "sw_pre_d");
        cyc(C_R, 1'b1, B_EXR, "sw_pre_e");
        cyc(C_R, 1'b1, B_WBR, "sw_pre_wb");
        cyc(C_SW, 1'b1, B_F, "sw_fetch");
        cyc(C_SW, 1'b1, B_D, "sw_decode");
        cyc(C_SW, 1'b1, B_MA, "sw_addr");
        cyc(C_SW, 1'b0, B_MWR, "sw_wr0");
        check("sw_mw", {31'd0, s_vec[18]}, 32'd1);
        cyc(C_SW, 1'b0, B_MWR, "sw_wr1");
        check("sw_pre_count", count, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_vec", {6'd0, dut_vec}, 32'd0);
        check("midrst_mw", {31'd0, mw}, 32'd0);
        check("midrst_state", {28'd0, state}, 32'd0);
        check("midrst_count", count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(C_R, 1'b1, B_INIT, "post_init");
        cyc(C_R, 1'b1, B_F,    "post_fetch");

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin : rnd
            logic [3:0] cur;
            cur = m_seq[m_idx];
            if (rst) begin
                rst = 1'b0;
            end else if (cur == B_HALT || cur == B_TRAP || $urandom_range(0, 299) == 0) begin
                if ($urandom_range(0, 3) == 0) rst = 1'b1;
            end
            if (cur == B_F) begin
                case ($urandom_range(0, 29))
                    0:       opcode = C_HALT;
                    1:       opcode = 6'($urandom);
                    default: opcode = pick_ops[$urandom_range(0, 7)];
                endcase
            end
            mem_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised multicycle control unit; next generation of the existing 10-state multicycle controller.
- Sits beside the datapath and drives PC, IR, register-file, memory and ALU-mux controls from the IR opcode.
- Adds over the previous generation:
  - ADDI, BNE and JAL instructions.
  - Memory wait-state handshake.
  - Sticky HALT and illegal-opcode trap.
  - Retired-instruction counter.
  - Explicit INIT state.

Parameters:
OPCODE_W, 6, opcode field width
CNT_W, 32, retired-instruction counter width
MEM_WAIT_EN, 1, 1 = memory states stall on mem_ready; 0 = mem_ready ignored (treated as 1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
opcode  in  OPCODE_W  IR[31:26]; stable outside FETCH
mem_ready  in  1  memory completes the current access this cycle
pc_write / pc_write_cond / pc_write_cond_ne  out  1 each  PC unconditional / take-if-zero / take-if-not-zero
ir_write, reg_write, iord, mem_read, mem_write, alu_src_a  out  1 each  standard multicycle controls
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
reg_dst  out  2  00 rt, 01 rd, 10 $31
alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
beat  out  5  one-hot phase indicator
halted  out  1  sticky, HALT executed
illegal  out  1  sticky, undefined opcode trapped
retired_count  out  CNT_W  retired instructions
state_out  out  4  current state encoding

Behaviour:
- Reset and output decode:
  - rst high forces state INIT immediately (async); retired_count=0.
  - All outputs are a combinational decode of state (plus mem_ready gating), so during reset every output is 0.
  - Any control not listed for a state is 0.
- State list, controls and next state:
  - INIT: all outputs 0, beat 00000 -> FETCH.
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; pc_write=ir_write=mem_ready; beat 00001. Hold until mem_ready, then -> DECODE.
  - DECODE: alu_src_b=11, alu_op=00, beat 00010. Dispatch on opcode:
    - LW 100011, SW 101011 -> MEM_ADDR
    - R 000000 -> EXEC_R
    - ADDI 001000 -> EXEC_I
    - BEQ 000100, BNE 000101 -> BRANCH
    - J 000010 -> JUMP
    - JAL 000011 -> JAL
    - HALT 111111 -> HALT
    - any other opcode -> TRAP
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, beat 00100 -> MEM_RD (LW) / MEM_WR (SW).
  - MEM_RD: iord=1, mem_read=1, beat 01000; hold until mem_ready -> WB_MEM.
  - WB_MEM: reg_write=1, mem_to_reg=01, reg_dst=00, beat 10000 -> FETCH.
  - MEM_WR: iord=1, mem_write=1 held through all wait cycles, beat 01000; on mem_ready -> FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, beat 00100 -> WB_R.
  - WB_R: reg_write=1, reg_dst=01, mem_to_reg=00, beat 01000 -> FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00, beat 00100 -> WB_I.
  - WB_I: reg_write=1, reg_dst=00, mem_to_reg=00, beat 01000 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write_cond=1 only for BEQ, pc_write_cond_ne=1 only for BNE; beat 00100 -> FETCH.
  - JUMP: pc_write=1, pc_source=10, beat 00100 -> FETCH.
  - JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, beat 00100 -> FETCH. PC already holds PC+4 from FETCH.
  - HALT: halted=1, all strobes 0, beat 00000; absorbing until rst.
  - TRAP: illegal=1, all strobes 0, beat 00000; absorbing until rst.
- Latencies (mem_ready=1 throughout): LW 5 cycles; SW, R, ADDI 4; BEQ, BNE, J, JAL 3.
- retired_count:
  - +1 on the clock edge of every transition into FETCH from WB_MEM, MEM_WR, WB_R, WB_I, BRANCH, JUMP or JAL.
  - +1 on DECODE->HALT.
  - Never incremented on TRAP or INIT->FETCH.
  - Wraps modulo 2^CNT_W.
- Wait states: mem_ready is sampled only in FETCH, MEM_RD and MEM_WR. With MEM_WAIT_EN=0 those states each last exactly 1 cycle.
- Reset mid-instruction: the in-flight instruction is abandoned and not counted; halted and illegal clear.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the 4-bit state encodings (INIT=0, FETCH=1, then the rest in the order listed);
  - opcode constants;
  - alu_op, alu_src_b, mem_to_reg, reg_dst and pc_source codes;
  - beat one-hot constants.
- One natural sub-module: mc_ctrl_decode, a pure combinational state + mem_ready -> control-vector decode. The state register, next-state logic and counter stay in the top.

Test Plan:
- Reset release, opcode=000000, mem_ready=1 -> state sequence INIT, FETCH, DECODE, EXEC_R, WB_R, FETCH; reg_write=1 and reg_dst=01 in WB_R only; retired_count 0->1.
- LW with mem_ready low 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles with iord=1, mem_read=1; WB_MEM mem_to_reg=01; total 7 cycles; count +1.
- BNE then BEQ -> BRANCH asserts pc_write_cond_ne only (BNE), then pc_write_cond only (BEQ); pc_source=01, alu_op=01 in both.
- JAL -> JAL state asserts pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10, pc_source=10 for one cycle.
- opcode=111111 -> halted=1 and held 20 cycles, count +1, all strobes 0. Repeat from reset with opcode=010101 -> illegal=1, count unchanged.
- rst asserted mid-SW while MEM_WR is stalled -> outputs all 0 the same cycle, mem_write drops, count=0; after release, first edge enters FETCH.
